// File: rtl/mode_sequencer.sv
// Display-mode sequencer: debounced mode button, countdown-timer override,
// alert flag and post-change display blanking.
module mode_sequencer #(
   parameter int unsigned DEB_CYCLES   = 4,
   parameter int unsigned BLANK_CYCLES = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_mode,
   input  logic       lock_i,
   input  logic       tmr_done,
   output logic [1:0] ct_o,
   output logic       mode_chg_o,
   output logic       blank_o,
   output logic       alert_o
);

   localparam logic [15:0] DEB_LAST   = 16'(DEB_CYCLES - 1);
   localparam logic [7:0]  BLANK_LOAD = 8'(BLANK_CYCLES - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BLANK = 1'b1
   } state_t;

   logic        sync1_q, btn_s_q;
   logic        btn_d_q, btn_d_d;
   logic        btn_dly_q;
   logic        press_q, press_d;
   logic [15:0] deb_cnt_q, deb_cnt_d;
   logic [1:0]  ct_q, ct_d;
   logic        alert_q, alert_d;
   logic        mode_chg_q;
   logic        chg_s;
   state_t      state_q, state_d;
   logic [7:0]  blk_cnt_q, blk_cnt_d;
   logic        blank_q, blank_d;

   // Debounce: accept btn_s only after it has differed from btn_d for DEB_CYCLES cycles.
   always_comb begin
      btn_d_d   = btn_d_q;
      deb_cnt_d = 16'd0;
      if (btn_s_q != btn_d_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            btn_d_d   = btn_s_q;
            deb_cnt_d = 16'd0;
         end else begin
            deb_cnt_d = deb_cnt_q + 16'd1;
         end
      end else begin
         deb_cnt_d = 16'd0;
      end
      press_d = btn_d_q & ~btn_dly_q;
   end

   // Mode select: timer expiry overrides a press arriving in the same cycle.
   always_comb begin
      ct_d    = ct_q;
      alert_d = alert_q;
      if (tmr_done) begin
         ct_d    = 2'b11;
         alert_d = 1'b1;
      end else if (press_q && !lock_i) begin
         ct_d    = ct_q + 2'd1;
         alert_d = 1'b0;
      end else begin
         ct_d    = ct_q;
         alert_d = alert_q;
      end
      chg_s = (ct_d != ct_q);
   end

   // Blanking FSM: any mode change (re)starts a full blank period.
   always_comb begin
      state_d   = state_q;
      blk_cnt_d = blk_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (chg_s) begin
               state_d   = ST_BLANK;
               blk_cnt_d = BLANK_LOAD;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_BLANK: begin
            if (chg_s) begin
               blk_cnt_d = BLANK_LOAD;
            end else if (blk_cnt_q == 8'd0) begin
               state_d   = ST_IDLE;
            end else begin
               blk_cnt_d = blk_cnt_q - 8'd1;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            blk_cnt_d = 8'd0;
         end
      endcase
      blank_d = (state_d == ST_BLANK);
   end

   // State registers; every output is a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= 1'b0;
         btn_s_q    <= 1'b0;
         btn_d_q    <= 1'b0;
         btn_dly_q  <= 1'b0;
         press_q    <= 1'b0;
         deb_cnt_q  <= 16'd0;
         ct_q       <= 2'b00;
         alert_q    <= 1'b0;
         mode_chg_q <= 1'b0;
         state_q    <= ST_IDLE;
         blk_cnt_q  <= 8'd0;
         blank_q    <= 1'b0;
      end else begin
         sync1_q    <= btn_mode;
         btn_s_q    <= sync1_q;
         btn_d_q    <= btn_d_d;
         btn_dly_q  <= btn_d_q;
         press_q    <= press_d;
         deb_cnt_q  <= deb_cnt_d;
         ct_q       <= ct_d;
         alert_q    <= alert_d;
         mode_chg_q <= chg_s;
         state_q    <= state_d;
         blk_cnt_q  <= blk_cnt_d;
         blank_q    <= blank_d;
      end
   end

   assign ct_o       = ct_q;
   assign mode_chg_o = mode_chg_q;
   assign blank_o    = blank_q;
   assign alert_o    = alert_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Bench for mode_sequencer: directed scenarios plus random button/lock/timer
// traffic, compared every cycle against an event-level reference model.
module tb_mode_sequencer;

   localparam int DEB   = 4;
   localparam int BLANK = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_mode;
   logic       lock_i;
   logic       tmr_done;
   logic [1:0] ct_o;
   logic       mode_chg_o;
   logic       blank_o;
   logic       alert_o;

   int checks = 0;
   int errors = 0;

   mode_sequencer #(.DEB_CYCLES(DEB), .BLANK_CYCLES(BLANK)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_mode   (btn_mode),
      .lock_i     (lock_i),
      .tmr_done   (tmr_done),
      .ct_o       (ct_o),
      .mode_chg_o (mode_chg_o),
      .blank_o    (blank_o),
      .alert_o    (alert_o)
   );

   always #5 clk = ~clk;

   // Reference model: edge counter, sample history, window-based debounce,
   // scheduled press events and a blank deadline.
   int         edge_n;
   bit         samp_q[$];
   bit         bs_hist[$];
   bit         deb;
   int         press_due[$];
   logic [1:0] m_ct;
   bit         m_alert;
   bit         m_chg;
   int         blank_end;

   function automatic void model_reset();
      edge_n = 0;
      samp_q.delete();
      bs_hist.delete();
      deb = 1'b0;
      press_due.delete();
      m_ct = 2'b00;
      m_alert = 1'b0;
      m_chg = 1'b0;
      blank_end = 0;
   endfunction

   function automatic void model_edge(input bit b, input bit lk, input bit td);
      bit bs;
      bit all_diff;
      bit press;
      edge_n++;
      // button level seen by the debouncer at this edge = sample taken two edges ago
      bs = (samp_q.size() >= 2) ? samp_q[samp_q.size()-2] : 1'b0;
      samp_q.push_back(b);
      if (samp_q.size() > 4) void'(samp_q.pop_front());
      bs_hist.push_back(bs);
      if (bs_hist.size() > DEB) void'(bs_hist.pop_front());
      press = 1'b0;
      if (press_due.size() > 0 && press_due[0] == edge_n) begin
         press = 1'b1;
         void'(press_due.pop_front());
      end
      all_diff = (bs_hist.size() == DEB);
      foreach (bs_hist[i]) if (bs_hist[i] == deb) all_diff = 1'b0;
      if (all_diff) begin
         deb = ~deb;
         if (deb) press_due.push_back(edge_n + 2);
      end
      m_chg = 1'b0;
      if (td) begin
         m_alert = 1'b1;
         if (m_ct != 2'b11) begin
            m_ct = 2'b11;
            m_chg = 1'b1;
         end
      end else if (press && !lk) begin
         m_ct = m_ct + 2'd1;
         m_alert = 1'b0;
         m_chg = 1'b1;
      end
      if (m_chg) blank_end = edge_n + BLANK;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge(btn_mode, lock_i, tmr_done);
      #1;
      chk("ct_o", 32'(ct_o), 32'(m_ct));
      chk("mode_chg_o", 32'(mode_chg_o), 32'(m_chg));
      chk("blank_o", 32'(blank_o), 32'(edge_n < blank_end));
      chk("alert_o", 32'(alert_o), 32'(m_alert));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ct"}, 32'(ct_o), 32'd0);
      chk({tag, "_chg"}, 32'(mode_chg_o), 32'd0);
      chk({tag, "_blank"}, 32'(blank_o), 32'd0);
      chk({tag, "_alert"}, 32'(alert_o), 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk_zero("reset");
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic press(input int n_high, input int n_low);
      btn_mode = 1'b1;
      repeat (n_high) cycle();
      btn_mode = 1'b0;
      repeat (n_low) cycle();
   endtask

   initial begin
      int first_e;
      int chg_edge;
      int blank_cnt;
      int n_adv;
      bit hit;
      bit found;

      rst_n = 1'b0;
      btn_mode = 1'b0;
      lock_i = 1'b0;
      tmr_done = 1'b0;
      model_reset();
      do_reset();

      // clean press: latency and blank length
      first_e = edge_n + 1;
      chg_edge = -1;
      blank_cnt = 0;
      btn_mode = 1'b1;
      for (int i = 0; i < 22; i++) begin
         if (i == 10) btn_mode = 1'b0;
         cycle();
         if (mode_chg_o === 1'b1 && chg_edge < 0) chg_edge = edge_n;
         if (blank_o === 1'b1) blank_cnt++;
      end
      chk("press_latency", 32'(chg_edge - first_e), 32'(2 + DEB + 1));
      chk("clean_blank_len", 32'(blank_cnt), 32'(BLANK));
      chk("clean_ct", 32'(ct_o), 32'd1);

      // bounce: no advance, then a steady hold gives exactly one
      for (int r = 0; r < 6; r++) press(3, 1);
      repeat (8) cycle();
      chk("bounce_ct", 32'(ct_o), 32'd1);
      n_adv = 0;
      btn_mode = 1'b1;
      for (int i = 0; i < 24; i++) begin
         if (i == 10) btn_mode = 1'b0;
         cycle();
         if (mode_chg_o === 1'b1) n_adv++;
      end
      chk("bounce_advances", 32'(n_adv), 32'd1);
      chk("bounce_ct_after", 32'(ct_o), 32'd2);

      // wrap: 10 -> 11 -> 00 -> 01 -> 10
      n_adv = 0;
      for (int p = 0; p < 4; p++) begin
         btn_mode = 1'b1;
         for (int i = 0; i < 22; i++) begin
            if (i == 10) btn_mode = 1'b0;
            cycle();
            if (mode_chg_o === 1'b1) n_adv++;
         end
         chk("wrap_ct", 32'(ct_o), 32'((p + 3) % 4));
      end
      chk("wrap_pulses", 32'(n_adv), 32'd4);

      // timer coincident with press pulse at ct=01
      for (int g = 0; g < 4 && m_ct != 2'b01; g++) press(10, 12);
      chk("prio_pre_ct", 32'(ct_o), 32'd1);
      hit = 1'b0;
      btn_mode = 1'b1;
      for (int i = 0; i < 40 && !hit; i++) begin
         tmr_done = (press_due.size() > 0 && press_due[0] == edge_n + 1);
         if (tmr_done) hit = 1'b1;
         if (i >= 10) btn_mode = 1'b0;
         cycle();
      end
      tmr_done = 1'b0;
      btn_mode = 1'b0;
      chk("prio_hit", 32'(hit), 32'd1);
      chk("prio_ct", 32'(ct_o), 32'd3);
      chk("prio_alert", 32'(alert_o), 32'd1);
      repeat (12) cycle();
      chk("prio_hold_ct", 32'(ct_o), 32'd3);
      press(10, 12);
      chk("prio_next_ct", 32'(ct_o), 32'd0);
      chk("prio_next_alert", 32'(alert_o), 32'd0);

      // lock: press ignored, timer still forces 11
      lock_i = 1'b1;
      press(10, 12);
      chk("lock_ct", 32'(ct_o), 32'd0);
      chk("lock_alert", 32'(alert_o), 32'd0);
      tmr_done = 1'b1;
      cycle();
      tmr_done = 1'b0;
      chk("lock_tmr_ct", 32'(ct_o), 32'd3);
      repeat (4) cycle();
      press(10, 12);
      chk("lock_keeps_alert", 32'(alert_o), 32'd1);
      lock_i = 1'b0;

      // back-to-back changes two cycles apart
      found = 1'b0;
      btn_mode = 1'b1;
      for (int i = 0; i < 30 && !found; i++) begin
         cycle();
         if (m_chg) found = 1'b1;
      end
      btn_mode = 1'b0;
      blank_cnt = (blank_o === 1'b1) ? 1 : 0;
      cycle();
      if (blank_o === 1'b1) blank_cnt++;
      tmr_done = 1'b1;
      cycle();
      tmr_done = 1'b0;
      if (blank_o === 1'b1) blank_cnt++;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (blank_o === 1'b1) blank_cnt++;
      end
      chk("b2b_found", 32'(found), 32'd1);
      chk("b2b_blank_len", 32'(blank_cnt), 32'd5);
      chk("b2b_ct", 32'(ct_o), 32'd3);

      // reset one cycle after a mode change
      found = 1'b0;
      btn_mode = 1'b1;
      for (int i = 0; i < 30 && !found; i++) begin
         cycle();
         if (m_chg) found = 1'b1;
      end
      btn_mode = 1'b0;
      cycle();
      chk("midblank_blank_pre", 32'(blank_o), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("async_reset");
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      blank_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (blank_o === 1'b1) blank_cnt++;
      end
      chk("post_reset_blank", 32'(blank_cnt), 32'd0);

      // button held through reset release
      btn_mode = 1'b1;
      do_reset();
      repeat (12) cycle();
      chk("held_reset_ct", 32'(ct_o), 32'd1);
      btn_mode = 1'b0;
      repeat (12) cycle();

      // random traffic
      for (int k = 0; k < 300; k++) begin
         int n;
         btn_mode = 1'($urandom_range(0, 1));
         lock_i = ($urandom_range(0, 4) == 0);
         n = $urandom_range(1, 9);
         for (int j = 0; j < n; j++) begin
            tmr_done = ($urandom_range(0, 39) == 0);
            cycle();
         end
      end
      tmr_done = 1'b0;
      repeat (5) cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
